fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 128 ++++++++++++
 tb/tb_fetch_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular FIFO between fetch and decode, with exception poisoning
//            and flush. Define FETCH_QUEUE_BYPASS_EN for an empty-queue bypass.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [31:0]              in_PC,
   input  logic [31:0]              in_instruction,
   input  logic [2:0]               in_exception_vector,
   input  logic                     in_flush,
   input  logic                     in_decode_ready,
   output logic                     out_valid,
   output logic [31:0]              out_PC,
   output logic [31:0]              out_instruction,
   output logic [2:0]               out_exception_vector,
   output logic                     out_full,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

   logic [31:0]        r_pc_mem    [DEPTH];
   logic [31:0]        r_instr_mem [DEPTH];
   logic [2:0]         r_exc_mem   [DEPTH];

   logic [c_ptr_w-1:0] r_head;
   logic [c_ptr_w-1:0] r_tail;
   logic [c_cnt_w-1:0] r_count;
   logic               r_poisoned;

   logic               w_not_empty;
   logic               w_full;
   logic               w_enq;
   logic               w_deq;
   logic               w_accept;
   logic               w_bypass;

   assign w_not_empty = (r_count != '0);
   // A poisoned queue reports full so fetch stops advancing the PC.
   assign w_full      = (r_count == c_depth) || r_poisoned;
   assign w_deq       = w_not_empty && in_decode_ready && !in_flush;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic w_bypass_take;

   assign w_bypass      = !reset && !w_not_empty && in_valid && !r_poisoned && !in_flush;
   // A bypassed entry consumed by decode in the same cycle is never written.
   assign w_bypass_take = w_bypass && in_decode_ready;
   assign w_enq         = in_valid && !w_full && !in_flush && !w_bypass_take;
   assign w_accept      = w_enq || w_bypass_take;
`else
   assign w_bypass      = 1'b0;
   assign w_enq         = in_valid && !w_full && !in_flush;
   assign w_accept      = w_enq;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_poisoned <= 1'b0;
      end else if (in_flush) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_poisoned <= 1'b0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + c_ptr_one;
         end
         if (w_deq) begin
            r_head <= r_head + c_ptr_one;
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + c_cnt_one;
         end else if (!w_enq && w_deq) begin
            r_count <= r_count - c_cnt_one;
         end
         if (w_accept && (in_exception_vector != 3'd0)) begin
            r_poisoned <= 1'b1;
         end
      end
   end

   // Storage carries no reset: contents are only observable through count.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_pc_mem[r_tail]    <= in_PC;
         r_instr_mem[r_tail] <= in_instruction;
         r_exc_mem[r_tail]   <= in_exception_vector;
      end
   end

   always_comb begin
      out_valid            = 1'b0;
      out_PC               = 32'd0;
      out_instruction      = 32'd0;
      out_exception_vector = 3'd0;
      if (w_not_empty) begin
         out_valid            = 1'b1;
         out_PC               = r_pc_mem[r_head];
         out_instruction      = r_instr_mem[r_head];
         out_exception_vector = r_exc_mem[r_head];
      end else if (w_bypass) begin
         out_valid            = 1'b1;
         out_PC               = in_PC;
         out_instruction      = in_instruction;
         out_exception_vector = in_exception_vector;
      end
   end

   assign out_full  = w_full;
   assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// Testbench for fetch_queue: directed scenarios plus random traffic checked
// against a queue-based reference model by a negedge monitor.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [2:0]  exc;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_PC = 32'd0;
   logic [31:0] in_instruction = 32'd0;
   logic [2:0]  in_exception_vector = 3'd0;
   logic        in_flush = 1'b0;
   logic        in_decode_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_PC;
   logic [31:0] out_instruction;
   logic [2:0]  out_exception_vector;
   logic        out_full;
   logic [$clog2(DEPTH):0] out_count;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .reset                (reset),
      .in_valid             (in_valid),
      .in_PC                (in_PC),
      .in_instruction       (in_instruction),
      .in_exception_vector  (in_exception_vector),
      .in_flush             (in_flush),
      .in_decode_ready      (in_decode_ready),
      .out_valid            (out_valid),
      .out_PC               (out_PC),
      .out_instruction      (out_instruction),
      .out_exception_vector (out_exception_vector),
      .out_full             (out_full),
      .out_count            (out_count)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   ent_t exp_q[$];
   bit   m_poisoned = 0;
   bit   m_enq, m_deq, m_byp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queue of accepted entries plus a poison flag.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         m_poisoned = 0;
      end else if (in_flush) begin
         exp_q.delete();
         m_poisoned = 0;
      end else begin
         m_byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
         m_byp = (exp_q.size() == 0) && in_valid && !m_poisoned && in_decode_ready;
`endif
         m_deq = (exp_q.size() != 0) && in_decode_ready;
         m_enq = in_valid && !((exp_q.size() == DEPTH) || m_poisoned) && !m_byp;
         if (m_deq) void'(exp_q.pop_front());
         if (m_enq) exp_q.push_back('{pc: in_PC, ins: in_instruction, exc: in_exception_vector});
         if ((m_enq || m_byp) && in_exception_vector != 3'd0) m_poisoned = 1;
      end
   end

   // Monitor: compares what the DUT presents against the model's head.
   ent_t mon_h;
   logic mon_v;
   always @(negedge clk) begin
      mon_v = 1'b0;
      mon_h = '0;
      if (exp_q.size() != 0) begin
         mon_v = 1'b1;
         mon_h = exp_q[0];
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (!reset && in_valid && !m_poisoned && !in_flush) begin
         mon_v = 1'b1;
         mon_h = '{pc: in_PC, ins: in_instruction, exc: in_exception_vector};
      end
`endif
      check("mon_valid", {31'd0, out_valid}, {31'd0, mon_v});
      check("mon_pc", out_PC, mon_h.pc);
      check("mon_instr", out_instruction, mon_h.ins);
      check("mon_exc", {29'd0, out_exception_vector}, {29'd0, mon_h.exc});
      check("mon_count", {29'd0, out_count}, exp_q.size());
      check("mon_full", {31'd0, out_full},
            {31'd0, ((exp_q.size() == DEPTH) || m_poisoned)});
   end

   task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] exc,
                        input logic fl, input logic rdy);
      in_valid            = v;
      in_PC               = pc;
      in_instruction      = ~pc;
      in_exception_vector = exc;
      in_flush            = fl;
      in_decode_ready     = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("reset_valid", {31'd0, out_valid}, 0);
      check("reset_count", {29'd0, out_count}, 0);
      check("reset_full", {31'd0, out_full}, 0);
      check("reset_pc", out_PC, 0);

      // Fill to DEPTH, then a fifth enqueue is dropped
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h1000 + 4 * i, 0, 0, 0);
         step();
      end
      check("fill_count", {29'd0, out_count}, 4);
      check("fill_full", {31'd0, out_full}, 1);
      check("fill_pc", out_PC, 32'h1000);
      drive(1, 32'h1010, 0, 0, 0);
      step();
      check("drop5_count", {29'd0, out_count}, 4);
      check("drop5_pc", out_PC, 32'h1000);

      // Drain in order
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", out_PC, 32'h1000 + 4 * i);
         step();
      end
      check("drain_valid", {31'd0, out_valid}, 0);
      check("drain_pc0", out_PC, 0);

      // Steady state with count 2 and simultaneous enq/deq, pointers wrap
      drive(1, 32'h2000, 0, 0, 0);
      step();
      drive(1, 32'h2004, 0, 0, 0);
      step();
      for (int i = 0; i < 6; i++) begin
         drive(1, 32'h2008 + 4 * i, 0, 0, 1);
         check("wrap_pc", out_PC, 32'h2000 + 4 * i);
         step();
         check("wrap_count", {29'd0, out_count}, 2);
      end
      drive(0, 0, 0, 0, 1);
      step();
      step();
      check("wrap_empty", {29'd0, out_count}, 0);

      // Exception poisons the queue until a flush
      drive(1, 32'h3000, 3'b001, 0, 0);
      step();
      check("poison_full", {31'd0, out_full}, 1);
      check("poison_exc", {29'd0, out_exception_vector}, 1);
      drive(1, 32'h3004, 0, 0, 0);
      step();
      check("poison_drop", {29'd0, out_count}, 1);
      drive(0, 0, 0, 1, 0);
      step();
      check("flush_count", {29'd0, out_count}, 0);
      check("flush_full", {31'd0, out_full}, 0);

      // Flush outranks same-cycle enqueue and dequeue
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h3100 + 4 * i, 0, 0, 0);
         step();
      end
      drive(1, 32'h3200, 0, 1, 1);
      step();
      check("flushpri_count", {29'd0, out_count}, 0);
      check("flushpri_valid", {31'd0, out_valid}, 0);

      // Empty-queue latency / bypass
      drive(1, 32'h4000, 0, 0, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
      check("byp_valid", {31'd0, out_valid}, 1);
      check("byp_pc", out_PC, 32'h4000);
      step();
      check("byp_count", {29'd0, out_count}, 0);
`else
      check("lat_valid0", {31'd0, out_valid}, 0);
      drive(0, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      drive(1, 32'h4000, 0, 0, 1);
      step();
      check("lat_valid1", {31'd0, out_valid}, 1);
      check("lat_pc", out_PC, 32'h4000);
`endif
      drive(0, 0, 0, 0, 1);
      step();

      // Asynchronous reset mid-operation
      drive(1, 32'h5000, 0, 0, 0);
      step();
      drive(1, 32'h5004, 0, 0, 1);
      #3;
      reset = 1'b1;
      #1;
      check("areset_valid", {31'd0, out_valid}, 0);
      check("areset_count", {29'd0, out_count}, 0);
      check("areset_pc", out_PC, 0);
      drive(1, 32'h5008, 0, 1, 1);
      step();
      check("inreset_count", {29'd0, out_count}, 0);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      step();
      check("postreset_count", {29'd0, out_count}, 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom % 4) != 0, $urandom,
               (($urandom % 24) == 0) ? 3'(1 + $urandom % 7) : 3'd0,
               ($urandom % 40) == 0, ($urandom % 3) != 0);
         in_instruction = $urandom;
         reset = (($urandom % 400) == 0);
         step();
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
